// File: rtl/fa_share_arb.sv
// fa_share_arb: round-robin arbiter/sequencer that time-shares a single
// fa_nbit_param ripple adder among NREQ valid/ready requesters.
// Optional feature macro: FA_SHARE_ARB_SUB_EN adds a per-requester req_sub
// input; a latched sub=1 makes the operation a - b (cout=1 means no borrow).
// Each operation takes IDLE (grant) -> CALC (adder evaluates) -> RESP (hold
// result until consumed), so peak throughput is one result every 3 cycles.

// Plain ripple-carry adder, one full-adder cell per bit.
module fa_nbit_param #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin_i;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum_o[gi]     = a_i[gi] ^ b_i[gi] ^ carry[gi];
            assign carry[gi + 1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
        end
    endgenerate

    assign cout_o = carry[WIDTH];

endmodule

module fa_share_arb #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 3,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
`ifdef FA_SHARE_ARB_SUB_EN
    input  logic [NREQ-1:0]       req_sub,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Pointer reset value: last winner = NREQ-1 gives requester 0 top priority.
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_cin_q, op_cin_d;
    logic [IDW-1:0]   op_id_q, op_id_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
`ifdef FA_SHARE_ARB_SUB_EN
    logic             op_sub_q, op_sub_d;
`endif

    // ------------------------------------------------------------------
    // Round-robin arbitration.
    // Requests with an index above the last winner are preferred; if none
    // exist the search wraps to the full request vector. The lowest set bit
    // of the chosen vector is isolated with the two's-complement trick.
    // ------------------------------------------------------------------
    logic [NREQ-1:0] above_last;
    logic [NREQ-1:0] hi_req;
    logic [NREQ-1:0] pick_vec;
    logic [NREQ-1:0] grant_oh;
    logic            any_req;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
            assign above_last[gi] = (IDW'(gi) > last_q);
        end
    endgenerate

    assign hi_req   = req_valid & above_last;
    assign pick_vec = (|hi_req) ? hi_req : req_valid;
    assign grant_oh = pick_vec & (~pick_vec + NREQ'(1));
    assign any_req  = |req_valid;

    // One-hot grant to index and operand selection, built as AND-OR chains
    // so every select uses a constant index.
    logic [NREQ:0][IDW-1:0]   id_chain;
    logic [NREQ:0][WIDTH-1:0] a_chain;
    logic [NREQ:0][WIDTH-1:0] b_chain;
    logic [NREQ:0]            cin_chain;
`ifdef FA_SHARE_ARB_SUB_EN
    logic [NREQ:0]            sub_chain;
`endif

    assign id_chain[0]  = '0;
    assign a_chain[0]   = '0;
    assign b_chain[0]   = '0;
    assign cin_chain[0] = 1'b0;
`ifdef FA_SHARE_ARB_SUB_EN
    assign sub_chain[0] = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
            assign id_chain[gi + 1]  = id_chain[gi] | (grant_oh[gi] ? IDW'(gi) : '0);
            assign a_chain[gi + 1]   = a_chain[gi] |
                                       ({WIDTH{grant_oh[gi]}} & req_a[gi*WIDTH +: WIDTH]);
            assign b_chain[gi + 1]   = b_chain[gi] |
                                       ({WIDTH{grant_oh[gi]}} & req_b[gi*WIDTH +: WIDTH]);
            assign cin_chain[gi + 1] = cin_chain[gi] | (grant_oh[gi] & req_cin[gi]);
`ifdef FA_SHARE_ARB_SUB_EN
            assign sub_chain[gi + 1] = sub_chain[gi] | (grant_oh[gi] & req_sub[gi]);
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Shared adder, fed only from the operand registers so the request
    // ports never reach the carry chain directly.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

`ifdef FA_SHARE_ARB_SUB_EN
    // Subtraction as a + ~b + 1; the requester's carry-in is ignored.
    assign add_b   = op_sub_q ? ~op_b_q : op_b_q;
    assign add_cin = op_sub_q ? 1'b1    : op_cin_q;
`else
    assign add_b   = op_b_q;
    assign add_cin = op_cin_q;
`endif

    fa_nbit_param #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i    (op_a_q),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // ------------------------------------------------------------------
    // Sequencer.
    // ------------------------------------------------------------------

    // Next-state: grant in IDLE, capture adder result in CALC, hold in RESP.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_cin_d   = op_cin_q;
        op_id_d    = op_id_q;
        rsp_id_d   = rsp_id_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
`ifdef FA_SHARE_ARB_SUB_EN
        op_sub_d   = op_sub_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    op_a_d   = a_chain[NREQ];
                    op_b_d   = b_chain[NREQ];
                    op_cin_d = cin_chain[NREQ];
                    op_id_d  = id_chain[NREQ];
`ifdef FA_SHARE_ARB_SUB_EN
                    op_sub_d = sub_chain[NREQ];
`endif
                    last_d   = id_chain[NREQ];
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                rsp_sum_d  = add_sum;
                rsp_cout_d = add_cout;
                rsp_id_d   = op_id_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= LAST_RST;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_cin_q   <= 1'b0;
            op_id_q    <= '0;
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
`ifdef FA_SHARE_ARB_SUB_EN
            op_sub_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_cin_q   <= op_cin_d;
            op_id_q    <= op_id_d;
            rsp_id_q   <= rsp_id_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
`ifdef FA_SHARE_ARB_SUB_EN
            op_sub_q   <= op_sub_d;
`endif
        end
    end

    // Grants are only visible while idle; the response side mirrors state.
    assign req_ready = (state_q == ST_IDLE) ? grant_oh : '0;
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_fa_share_arb.sv
// Self-checking bench for fa_share_arb (WIDTH=4, NREQ=3). Directed scenarios
// with literal expectations, then randomized traffic, all cross-checked every
// cycle against a transaction-level reference model.
// Honours FA_SHARE_ARB_SUB_EN when defined.
module tb_fa_share_arb;

    localparam int WIDTH = 4;
    localparam int NREQ  = 3;
    localparam int IDW   = 2;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic [NREQ-1:0]       req_sub;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fa_share_arb #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef FA_SHARE_ARB_SUB_EN
        .req_sub   (req_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Round-robin: first valid index scanning upward from last+1 with wrap.
    function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Returns {cout, sum} packed as an integer.
    function automatic int op_result(input int a, input int b, input int cin, input int sub);
`ifdef FA_SHARE_ARB_SUB_EN
        if (sub != 0) return ((a - b) & MASK) | ((a >= b) ? (1 << WIDTH) : 0);
`endif
        if (sub < 0) return 0;
        return a + b + cin;
    endfunction

    // One in-flight operation at most: its id, result and grant cycle.
    initial begin
        int  m_cyc, m_last, m_id, m_res, m_gcyc;
        bit  m_has_op;
        m_cyc = 0; m_last = NREQ - 1; m_has_op = 0; m_id = 0; m_res = 0; m_gcyc = 0;
        forever begin
            int pick, exp_ready, exp_busy, exp_rv, sub;
            @(negedge clk);
            pick = rr_pick(m_last, req_valid);
            if (!m_has_op) begin
                exp_ready = (pick >= 0) ? (1 << pick) : 0;
                exp_busy  = 0;
                exp_rv    = 0;
            end else begin
                exp_ready = 0;
                exp_busy  = 1;
                exp_rv    = (m_cyc >= m_gcyc + 2) ? 1 : 0;
            end
            chk("model_req_ready", int'(req_ready), exp_ready);
            chk("model_busy", int'(busy), exp_busy);
            chk("model_rsp_valid", int'(rsp_valid), exp_rv);
            if (exp_rv != 0) begin
                chk("model_rsp_id", int'(rsp_id), m_id);
                chk("model_rsp_sum", int'(rsp_sum), m_res & MASK);
                chk("model_rsp_cout", int'(rsp_cout), (m_res >> WIDTH) & 1);
            end
            if (rst) begin
                m_has_op = 0;
                m_last   = NREQ - 1;
            end else if (!m_has_op) begin
                if (pick >= 0) begin
                    sub = 0;
`ifdef FA_SHARE_ARB_SUB_EN
                    sub = int'(req_sub[pick]);
`endif
                    m_res    = op_result(int'(req_a[pick*WIDTH +: WIDTH]),
                                         int'(req_b[pick*WIDTH +: WIDTH]),
                                         int'(req_cin[pick]), sub);
                    m_id     = pick;
                    m_last   = pick;
                    m_gcyc   = m_cyc;
                    m_has_op = 1;
                end
            end else if (exp_rv != 0 && rsp_ready) begin
                m_has_op = 0;
            end
            m_cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input int a, input int b, input int c, input int s);
        req_valid[i]              = 1'b1;
        req_a[i*WIDTH +: WIDTH]   = WIDTH'(a);
        req_b[i*WIDTH +: WIDTH]   = WIDTH'(b);
        req_cin[i]                = c[0];
        req_sub[i]                = s[0];
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    // Lone request on an idle arbiter with rsp_ready high; 4 cycles.
    task automatic do_op(input int i, input int a, input int b, input int c, input int s,
                         input int esum, input int ecout, input string tag);
        set_req(i, a, b, c, s);
        settle();
        chk({tag, "_ready"}, int'(req_ready), 1 << i);
        adv();
        clr_req(i);
        settle();
        chk({tag, "_calc_busy"}, int'(busy), 1);
        chk({tag, "_calc_rv"}, int'(rsp_valid), 0);
        adv();
        settle();
        chk({tag, "_rv"}, int'(rsp_valid), 1);
        chk({tag, "_id"}, int'(rsp_id), i);
        chk({tag, "_sum"}, int'(rsp_sum), esum);
        chk({tag, "_cout"}, int'(rsp_cout), ecout);
        chk({tag, "_resp_busy"}, int'(busy), 1);
        adv();
        settle();
        chk({tag, "_idle_busy"}, int'(busy), 0);
        adv();
    endtask

    logic [NREQ-1:0] granted;

    initial begin
        logic [WIDTH-1:0] held_sum;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; req_sub = '0;
        rsp_ready = 1'b1; granted = '0;

        // Reset values
        adv(); adv();
        settle();
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_sum", int'(rsp_sum), 0);
        chk("rst_rsp_cout", int'(rsp_cout), 0);
        chk("rst_busy", int'(busy), 0);
        adv();
        rst = 1'b0;

        // Single request and arithmetic boundaries
        do_op(0, 9, 8, 1, 0, 2, 1, "single");
        do_op(1, 15, 15, 1, 0, 15, 1, "bnd_ff1");
        do_op(2, 0, 0, 0, 0, 0, 0, "bnd_000");
        do_op(0, 8, 8, 0, 0, 0, 1, "bnd_880");
`ifdef FA_SHARE_ARB_SUB_EN
        do_op(1, 3, 5, 1, 1, 14, 0, "sub_35");
        do_op(2, 5, 3, 0, 1, 2, 1, "sub_53");
`endif

        // Fairness from reset with all requesters continuously valid
        rst = 1'b1;
        adv();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 2 * i + 3, i % 2, 0);
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("fair_grant", int'(req_ready), 1 << (k % NREQ));
            adv();
            settle();
            chk("fair_busy", int'(busy), 1);
            adv();
            settle();
            chk("fair_rsp_id", int'(rsp_id), k % NREQ);
            adv();
        end
        req_valid = '0;

        // Backpressure: 4 cycles of rsp_ready low in RESP
        rsp_ready = 1'b0;
        set_req(2, 7, 6, 0, 0);
        settle();
        chk("bp_grant", int'(req_ready), 3'b100);
        adv();
        clr_req(2);
        set_req(0, 1, 2, 0, 0);
        adv();
        held_sum = rsp_sum;
        chk("bp_sum_first", int'(held_sum), 13);
        for (int j = 0; j < 4; j++) begin
            settle();
            chk("bp_rv_held", int'(rsp_valid), 1);
            chk("bp_sum_held", int'(rsp_sum), 13);
            chk("bp_cout_held", int'(rsp_cout), 0);
            chk("bp_id_held", int'(rsp_id), 2);
            chk("bp_no_grant", int'(req_ready), 0);
            adv();
        end
        rsp_ready = 1'b1;
        settle();
        chk("bp_accept_rv", int'(rsp_valid), 1);
        adv();
        settle();
        chk("bp_next_grant", int'(req_ready), 3'b001);
        chk("bp_after_rv", int'(rsp_valid), 0);
        adv();
        clr_req(0);
        repeat (3) adv();

        // Reset pulsed during CALC
        set_req(0, 1, 1, 0, 0);
        settle();
        chk("rmid_grant", int'(req_ready), 3'b001);
        adv();
        clr_req(0);
        rst = 1'b1;
        settle();
        chk("rmid_calc_busy", int'(busy), 1);
        adv();
        rst = 1'b0;
        set_req(1, 4, 5, 0, 0);
        set_req(2, 6, 7, 1, 0);
        settle();
        chk("rmid_no_rsp", int'(rsp_valid), 0);
        chk("rmid_idle", int'(busy), 0);
        chk("rmid_first", int'(req_ready), 3'b010);
        adv();
        clr_req(1);
        settle();
        chk("rmid_calc_no_rsp", int'(rsp_valid), 0);
        adv();
        settle();
        chk("rmid_rsp_id", int'(rsp_id), 1);
        chk("rmid_rsp_sum", int'(rsp_sum), 9);
        adv();
        settle();
        chk("rmid_second", int'(req_ready), 3'b100);
        adv();
        clr_req(2);
        repeat (3) adv();

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && granted[i]) begin
                    if ($urandom_range(0, 1) == 0)
                        set_req(i, $urandom_range(0, MASK), $urandom_range(0, MASK),
                                $urandom_range(0, 1), $urandom_range(0, 1));
                    else
                        clr_req(i);
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, $urandom_range(0, MASK), $urandom_range(0, MASK),
                                $urandom_range(0, 1), $urandom_range(0, 1));
                end else if ($urandom_range(0, 49) == 0) begin
                    clr_req(i);
                end
            end
            settle();
            granted = req_ready;
            adv();
        end

        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) adv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fa_share_arb.md
# fa_share_arb

Round-robin arbiter and sequencer that time-shares one `fa_nbit_param` ripple adder among `NREQ` requesters. Each requester presents operands under a valid/ready handshake. The block grants one requester at a time, registers its operands into the shared adder, and returns the registered sum and carry with the winner's ID under a valid/ready response handshake. It sits between the datapath clients and the single adder instance, so the client modules need no adders of their own.

## Interface
- `WIDTH`, default 4: operand and sum width, passed to the adder.
- `NREQ`, default 3: number of requesters, at least 2.
- `IDW`, default 2: width of `rsp_id`; must satisfy 2^IDW ≥ NREQ.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: per-requester request.
- `req_ready` out NREQ: per-requester accept; one-hot or zero.
- `req_a` in NREQ*WIDTH: packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b` in NREQ*WIDTH: packed operand B, same packing as `req_a`.
- `req_cin` in NREQ: per-requester carry-in.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out IDW: index of the requester being answered.
- `rsp_sum` out WIDTH: registered sum.
- `rsp_cout` out 1: registered carry-out.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states are IDLE, CALC and RESP. Reset state is IDLE.
- **IDLE:**
  - If any `req_valid` bit is set, choose a winner by round-robin, searching from index `last+1` mod NREQ upward with wrap.
  - Assert `req_ready[winner]` combinationally in the same cycle.
  - At the edge, latch `op_a`, `op_b`, `op_cin` and `op_id`, set `last`=winner, and go to CALC.
  - With no request, stay in IDLE and hold `req_ready`=0.
- **CALC:**
  - The adder is driven only from the `op_*` registers, never directly from the request ports.
  - At the edge, latch the adder outputs into `rsp_sum`/`rsp_cout`, copy `op_id` to `rsp_id`, and go to RESP.
- **RESP:**
  - `rsp_valid`=1 while in this state.
  - `rsp_sum`, `rsp_cout` and `rsp_id` stay stable until `rsp_valid && rsp_ready`.
  - On that handshake, go to IDLE.
- `req_ready` is 0 in both CALC and RESP. Requesters hold `req_valid` and their operands stable until they see `req_ready`. Requests that lose arbitration remain pending; the block never drops them.
- Arithmetic: {`rsp_cout`,`rsp_sum`} = a + b + cin, computed at WIDTH+1 bits. Wrap-around of `rsp_sum` is modulo 2^WIDTH, with the overflow reported only in `rsp_cout`.
- Round-robin pointer `last` resets to NREQ-1, so requester 0 has highest priority after reset. With all requesters continuously valid, the grant order is 0,1,…,NREQ-1,0,…
- `busy` = (state ≠ IDLE).

## Timing
- A request accepted in cycle T (`req_valid`&`req_ready` high) produces `rsp_valid`=1 from cycle T+2.
- If `rsp_ready` is high in cycle T+2, state is IDLE in T+3 and the next grant can occur in T+3. Peak throughput is one operation every 3 cycles.
- Response backpressure adds one cycle of latency per cycle `rsp_ready` is low, and no new grant is made during that time.
- Reset values:
  - Outputs: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_cout`=0, `busy`=0.
  - Internal: `op_*`=0, `last`=NREQ-1, FSM in IDLE.
- Reset asserted in any state, including mid-CALC or in RESP with `rsp_valid` high, aborts the in-flight operation. No response is emitted for it, and the next cycle after reset is IDLE.
- A `req_valid` bit that falls before its grant is simply not considered in later arbitration.

## Configuration
- Macro `FA_SHARE_ARB_SUB_EN`.
- **Defined:**
  - Adds input port `req_sub`, width NREQ, packed per requester; it is latched with the operands.
  - When the latched `sub` is 1, the adder receives `~op_b` and cin=1, and `req_cin` is ignored.
  - `rsp_sum` = a − b modulo 2^WIDTH; `rsp_cout`=1 means no borrow (a ≥ b).
  - When `sub` is 0, behaviour is identical to the undefined case.
- **Undefined:** the `req_sub` port and its registers are absent, and every operation is a + b + cin.

## Test plan
All scenarios use WIDTH=4, NREQ=3.
- **Single request:** req0 with a=4'h9, b=4'h8, cin=1 in cycle T, `rsp_ready`=1 → `req_ready`=3'b001 in T; in T+2, `rsp_valid`=1, `rsp_id`=0, `rsp_sum`=4'h2, `rsp_cout`=1; `busy` high in T+1 and T+2.
- **Fairness:** all three `req_valid` high continuously from reset, `rsp_ready`=1 → grants to 0,1,2,0,1,2 at 3-cycle spacing; each `rsp_id` matches its grant.
- **Backpressure:** `rsp_ready`=0 for 4 cycles during RESP → `rsp_*` held constant, `req_ready`=0 throughout, response accepted on the first cycle `rsp_ready`=1, and the next grant follows one cycle later.
- **Boundaries:** a=F, b=F, cin=1 → sum=F, cout=1; a=0, b=0, cin=0 → sum=0, cout=0; a=8, b=8, cin=0 → sum=0, cout=1.
- **Reset mid-operation:** `rst` pulsed in CALC → no `rsp_valid` ever appears for that request; after reset with req1 and req2 both valid, req1 is granted first.
- **`FA_SHARE_ARB_SUB_EN` defined:** a=3, b=5, sub=1 → sum=4'hE, cout=0; a=5, b=3, sub=1, req_cin=0 → sum=2, cout=1.
